multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock, rising edge.
REQ-002 SHALL have rst, in, 1; reset is synchronous and active-high on clk.
REQ-003 SHALL have opcode, in, 7, instruction bits [6:0] from the instruction register.
REQ-004 SHALL have funct3, in, 3, instruction bits [14:12].
REQ-005 SHALL have funct7_5, in, 1, instruction bit 30.
REQ-006 SHALL have zero, in, 1, ALU result == 0.
REQ-007 SHALL have neg, in, 1, ALU result bit 31.
REQ-008 SHALL have pc_write, ir_write, mem_write, reg_write, out, 1 each; write enables.
REQ-009 SHALL have adr_src, out, 1; 0 = PC, 1 = result.
REQ-010 SHALL have alu_src_a, out, 2; 0 = PC, 1 = old_pc, 2 = reg A.
REQ-011 SHALL have alu_src_b, out, 2; 0 = reg B, 1 = imm_ext, 2 = constant 4.
REQ-012 SHALL have result_src, out, 2; 0 = alu_out reg, 1 = mem data reg, 2 = ALU result, 3 = imm_ext.
REQ-013 SHALL have alu_control, out, 3; 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor.
REQ-014 SHALL have imm_src, out, 3; 0 I, 1 S, 2 B, 3 U, 4 J; drives the immediate extender select.

Function
REQ-015 All outputs SHALL be combinational from state and inputs; state SHALL be the only register.
REQ-016 imm_src SHALL be decoded from opcode in every state: lw/I-ALU/jalr->0, sw->1, branch->2, lui->3, jal->4, other->0.
REQ-017 Unlisted outputs in any state SHALL be 0; alu_control SHALL default to add.
REQ-018 FETCH: adr_src 0, ir_write 1, src_a 0, src_b 2, result_src 2, pc_write 1; next DECODE.
REQ-019 DECODE: src_a 1, src_b 1, add.
REQ-020 DECODE next state: lw(0000011)/sw(0100011)->MEM_ADR; R(0110011)->EXEC_R; I(0010011)->EXEC_I; jal(1101111)->JAL; jalr(1100111)->JALR_ADR; branch(1100011)->BRANCH; lui(0110111)->LUI; other->FETCH, with no write.
REQ-021 MEM_ADR: src_a 2, src_b 1, add; next MEM_READ for lw, MEM_WRITE for sw.
REQ-022 MEM_READ: adr_src 1, result_src 0; next MEM_WB. MEM_WB: result_src 1, reg_write 1; next FETCH.
REQ-023 MEM_WRITE: adr_src 1, result_src 0, mem_write 1; next FETCH.
REQ-024 EXEC_R: src_a 2, src_b 0. EXEC_I: src_a 2, src_b 1. Both go next to ALU_WB.
REQ-025 ALU decode from funct3: 000 add (sub if R and funct7_5=1), 111 and, 110 or, 010 slt, 100 xor, other add.
REQ-026 ALU_WB: result_src 0, reg_write 1; next FETCH.
REQ-027 JALR_ADR: src_a 2, src_b 1, add; next JAL.
REQ-028 JAL: src_a 1, src_b 2, add, result_src 0, pc_write 1; next ALU_WB, which writes old_pc+4 to rd.
REQ-029 BRANCH: src_a 2, src_b 0, sub, result_src 0; next FETCH.
REQ-030 In BRANCH, pc_write SHALL be 1 iff taken; funct3 000 zero, 001 !zero, 100 neg, 101 !neg, other never.
REQ-031 Cycle counts SHALL be lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3.
REQ-032 LUI: result_src 3, reg_write 1; next FETCH.

Reset
REQ-033 While rst=1, pc_write, ir_write, mem_write and reg_write SHALL be 0; other outputs SHALL hold their FETCH values.
REQ-034 On a clk edge with rst=1, state SHALL become FETCH from any state, including mid-instruction; no partial write SHALL complete.

Structure
REQ-035 A shared package SHALL hold opcode constants, the state enumeration, and the adr/src_a/src_b/result/alu_control/imm_src encodings; the extender SHALL use the same imm_src constants.
REQ-036 ALU decode (REQ-025) SHALL be one sub-module, alu_decoder; the FSM stays in multicycle_controller.

Verification
REQ-037 rst 1 for 2 cycles, then rst 0 -> all write enables 0 during reset; first cycle after reset is FETCH with ir_write=1, pc_write=1.
REQ-038 lw (opcode 0000011) -> state sequence FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB; reg_write=1 only in cycle 5, with result_src=1.
REQ-039 beq with zero=1, then zero=0 -> pc_write=1 in cycle 3 for the first and 0 for the second; bge with neg=0 -> pc_write=1.
REQ-040 R-type, funct3 000, funct7_5=1 -> alu_control 001 in EXEC_R; I-type, same fields -> 000.
REQ-041 jalr -> src_a 2 in cycle 3, pc_write=1 in cycle 4, reg_write=1 with result_src=0 in cycle 5; imm_src=0 throughout.
REQ-042 Opcode 1111111 -> FETCH, DECODE, FETCH with no reg/mem write; rst=1 during MEM_WRITE -> mem_write 0, next state FETCH.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller and the datapath it steers.
// Holds the RV32I opcode constants, the controller state enumeration and the
// encodings of every mux select and ALU operation driven by the controller.
// The immediate extender selects its format using the imm_src_t codes defined here.
package multicycle_controller_pkg;

    // Opcodes, instruction bits [6:0]
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Branch conditions, funct3
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ALU operations, funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_JAL,
        S_JALR_ADR,
        S_BRANCH,
        S_LUI
    } state_t;

    typedef enum logic {
        ADR_PC     = 1'b0,
        ADR_RESULT = 1'b1
    } adr_src_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_REG    = 2'd2
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_REG   = 2'd0,
        SRC_B_IMM   = 2'd1,
        SRC_B_FOUR  = 2'd2
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT  = 2'd0,
        RES_MEM_DATA = 2'd1,
        RES_ALU      = 2'd2,
        RES_IMM      = 2'd3
    } result_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_XOR = 3'b101
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic imm_src_t imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI:    return IMM_U;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;   // lw, I-ALU, jalr and anything unknown
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder for arithmetic instructions.
// Ports:
//   funct3      - instruction bits [14:12]
//   funct7_5    - instruction bit 30
//   is_r_type   - 1 when the instruction is register-register
//   alu_control - ALU operation (alu_ctrl_t encoding)
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_r_type,
    output logic [2:0] alu_control
);

    always_comb begin
        // NOTE: default assigned first so every path drives the output; no latch.
        alu_control = ALU_ADD;
        case (funct3)
            // Bit 30 selects sub only for R-type; in addi it is immediate data.
            F3_ADD_SUB: alu_control = (is_r_type && funct7_5) ? ALU_SUB : ALU_ADD;
            F3_AND:     alu_control = ALU_AND;
            F3_OR:      alu_control = ALU_OR;
            F3_SLT:     alu_control = ALU_SLT;
            F3_XOR:     alu_control = ALU_XOR;
            default:    alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main controller FSM for a multicycle RV32I subset processor.
// The state register is the only storage; all outputs are decoded
// combinationally from the state and the instruction/flag inputs.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   opcode, funct3, funct7_5       - fields of the instruction register
//   zero, neg                      - ALU result flags for branch resolution
//   pc_write, ir_write,
//   mem_write, reg_write           - write enables
//   adr_src, alu_src_a, alu_src_b,
//   result_src                     - datapath mux selects
//   alu_control                    - ALU operation
//   imm_src                        - immediate extender format select
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       neg,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic [2:0] imm_src
);

    state_t     state;
    state_t     next_state;
    logic       is_r_type;
    logic [2:0] decoded_alu;
    logic       branch_taken;

    assign is_r_type = (opcode == OP_R);

    alu_decoder u_alu_decoder (
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .is_r_type   (is_r_type),
        .alu_control (decoded_alu)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every reader of state sees the pre-edge value.
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR_ADR;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_FETCH;  // unknown: drop it
                endcase
            end
            S_MEM_ADR:  next_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: next_state = S_MEM_WB;
            S_EXEC_R,
            S_EXEC_I:   next_state = S_ALU_WB;
            S_JALR_ADR: next_state = S_JAL;
            // JAL reuses ALU_WB to write the link address computed in this state.
            S_JAL:      next_state = S_ALU_WB;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            F3_BEQ:  branch_taken = zero;
            F3_BNE:  branch_taken = !zero;
            F3_BLT:  branch_taken = neg;
            F3_BGE:  branch_taken = !neg;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        adr_src     = ADR_PC;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_REG;
        result_src  = RES_ALU_OUT;
        alu_control = ALU_ADD;
        imm_src     = imm_src_of(opcode);

        case (state)
            S_FETCH: begin
                // PC <= PC + 4 through the live ALU result while IR loads.
                adr_src    = ADR_PC;
                ir_write   = 1'b1;
                alu_src_a  = SRC_A_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                pc_write   = 1'b1;
            end
            S_DECODE: begin
                // Precompute branch/jal target old_pc + imm into alu_out.
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_ADR, S_JALR_ADR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                adr_src    = ADR_RESULT;
                result_src = RES_ALU_OUT;
            end
            S_MEM_WB: begin
                result_src = RES_MEM_DATA;
                reg_write  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src    = ADR_RESULT;
                result_src = RES_ALU_OUT;
                mem_write  = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a   = SRC_A_REG;
                alu_src_b   = SRC_B_REG;
                alu_control = decoded_alu;
            end
            S_EXEC_I: begin
                alu_src_a   = SRC_A_REG;
                alu_src_b   = SRC_B_IMM;
                alu_control = decoded_alu;
            end
            S_ALU_WB: begin
                result_src = RES_ALU_OUT;
                reg_write  = 1'b1;
            end
            S_JAL: begin
                // PC takes the target held in alu_out while the ALU forms old_pc + 4.
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU_OUT;
                pc_write   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = SRC_A_REG;
                alu_src_b   = SRC_B_REG;
                alu_control = ALU_SUB;
                result_src  = RES_ALU_OUT;
                pc_write    = branch_taken;
            end
            S_LUI: begin
                result_src = RES_IMM;
                reg_write  = 1'b1;
            end
            default: ;
        endcase

        // During reset present FETCH selects with every write suppressed, so an
        // instruction interrupted mid-flight cannot commit anything.
        if (rst) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            adr_src     = ADR_PC;
            alu_src_a   = SRC_A_PC;
            alu_src_b   = SRC_B_FOUR;
            result_src  = RES_ALU;
            alu_control = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each test queues the
// expected per-cycle control word of an instruction, drives the instruction
// fields, then pops and compares one entry per cycle on the falling edge.
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] BAD  = 7'b1111111;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic [2:0] imm_src;
    } ctrl_t;

    typedef struct {
        ctrl_t exp;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       neg;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_src;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .zero        (zero),
        .neg         (neg),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .adr_src     (adr_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .imm_src     (imm_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic ctrl_t mk(input logic pcw, irw, mw, rw, adr,
                                 input logic [1:0] a, b, res,
                                 input logic [2:0] alu, imm);
        ctrl_t c;
        c = '{pcw, irw, mw, rw, adr, a, b, res, alu, imm};
        return c;
    endfunction

    function automatic logic [2:0] imm_exp(input logic [6:0] op);
        case (op)
            SW:      return 3'd1;
            BR:      return 3'd2;
            LUI:     return 3'd3;
            JAL:     return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic f75, input logic is_r);
        case (f3)
            3'b000:  return (is_r && f75) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b010:  return 3'b100;
            3'b100:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic taken_exp(input logic [2:0] f3, input logic z, input logic n);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n;
            3'b101:  return !n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input string tag, input ctrl_t e);
        exp_t x;
        x.exp = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // Expected control word sequence of one complete instruction from FETCH.
    task automatic queue_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic f75, input logic z, input logic n);
        logic [2:0] im;
        im = imm_exp(op);
        push({name, " fetch"},  mk(1, 1, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, im));
        push({name, " decode"}, mk(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd0, im));
        case (op)
            LW: begin
                push({name, " mem_adr"},  mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, im));
                push({name, " mem_read"}, mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, im));
                push({name, " mem_wb"},   mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 3'd0, im));
            end
            SW: begin
                push({name, " mem_adr"},   mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, im));
                push({name, " mem_write"}, mk(0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, im));
            end
            RT: begin
                push({name, " exec_r"}, mk(0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, alu_exp(f3, f75, 1'b1), im));
                push({name, " alu_wb"}, mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, im));
            end
            IT: begin
                push({name, " exec_i"}, mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, alu_exp(f3, f75, 1'b0), im));
                push({name, " alu_wb"}, mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, im));
            end
            JAL: begin
                push({name, " jal"},    mk(1, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0, im));
                push({name, " alu_wb"}, mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, im));
            end
            JALR: begin
                push({name, " jalr_adr"}, mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, im));
                push({name, " jal"},      mk(1, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0, im));
                push({name, " alu_wb"},   mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, im));
            end
            BR:  push({name, " branch"}, mk(taken_exp(f3, z, n), 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd1, im));
            LUI: push({name, " lui"},    mk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 3'd0, im));
            default: ;
        endcase
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic z, input logic n);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f75;
        zero     = z;
        neg      = n;
    endtask

    // One scoreboard entry per cycle; always ends 1 time unit after a rising edge.
    task automatic drain();
        exp_t  e;
        ctrl_t act;
        while (sb.size() > 0) begin
            @(negedge clk);
            e   = sb.pop_front();
            act = {pc_write, ir_write, mem_write, reg_write, adr_src,
                   alu_src_a, alu_src_b, result_src, alu_control, imm_src};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75, input logic z, input logic n);
        queue_instr(name, op, f3, f75, z, n);
        drive(op, f3, f75, z, n);
        drain();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(LW, 3'b000, 1'b0, 1'b0, 1'b0);
        push("reset c1", mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0));
        push("reset c2", mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0));
        drain();
        rst = 1'b0;
    endtask

    task automatic test_load_store();
        run("lw", LW, 3'b010, 1'b0, 1'b0, 1'b0);
        run("sw", SW, 3'b010, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_branch();
        run("beq z1",  BR, 3'b000, 1'b0, 1'b1, 1'b0);
        run("beq z0",  BR, 3'b000, 1'b0, 1'b0, 1'b0);
        run("bge n0",  BR, 3'b101, 1'b0, 1'b0, 1'b0);
        run("bge n1",  BR, 3'b101, 1'b0, 1'b0, 1'b1);
        run("bne z0",  BR, 3'b001, 1'b0, 1'b0, 1'b0);
        run("blt n1",  BR, 3'b100, 1'b0, 1'b0, 1'b1);
        run("br f3=2", BR, 3'b010, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_alu();
        run("r sub",  RT, 3'b000, 1'b1, 1'b0, 1'b0);
        run("i addi", IT, 3'b000, 1'b1, 1'b0, 1'b0);
        run("r add",  RT, 3'b000, 1'b0, 1'b0, 1'b0);
        run("r and",  RT, 3'b111, 1'b0, 1'b0, 1'b0);
        run("r or",   RT, 3'b110, 1'b0, 1'b0, 1'b0);
        run("i slt",  IT, 3'b010, 1'b0, 1'b0, 1'b0);
        run("r xor",  RT, 3'b100, 1'b1, 1'b0, 1'b0);
        run("r sll",  RT, 3'b001, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_jumps_lui();
        run("jal",  JAL,  3'b000, 1'b0, 1'b0, 1'b0);
        run("jalr", JALR, 3'b000, 1'b0, 1'b0, 1'b0);
        run("lui",  LUI,  3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_illegal();
        run("bad op", BAD, 3'b000, 1'b0, 1'b0, 1'b0);
        run("after bad", LW, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted while the store is in MEM_WRITE must cancel the write
    // and restart at FETCH.
    task automatic test_reset_mid();
        drive(SW, 3'b010, 1'b0, 1'b0, 1'b0);
        push("sw fetch",   mk(1, 1, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd1));
        push("sw decode",  mk(0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd0, 3'd1));
        push("sw mem_adr", mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 3'd1));
        drain();
        rst = 1'b1;
        push("rst in mem_write", mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd1));
        drain();
        rst = 1'b0;
        run("sw after rst", SW, 3'b010, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9];
        logic [6:0] op;
        ops = '{LW, SW, RT, IT, JAL, JALR, BR, LUI, BAD};
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(8)];
            run($sformatf("rand%0d op%b", i, op), op, 3'($urandom_range(7)),
                1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_branch();
        test_alu();
        test_jumps_lui();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
